// File: rtl/bias_pkg.sv
// Shared widths and FSM state encoding for the bias stream loader.
// Optional checksum framing is enabled with BIAS_CHECKSUM_EN.
package bias_pkg;

    localparam int unsigned BIAS_W  = 8;
    localparam int unsigned OUT_C_W = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    // Running 8-bit checksum; wraps modulo 256.
    function automatic logic [BIAS_W-1:0] csum_add(input logic [BIAS_W-1:0] acc,
                                                   input logic [BIAS_W-1:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/bias_stream_loader_if.sv
// Byte stream (valid/ready) carrying bias bytes into the loader.
interface bias_stream_loader_if;
    import bias_pkg::*;

    logic              valid;
    logic [BIAS_W-1:0] data;
    logic              ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/bias_regfile.sv
// Bias store: OC+1 byte entries, one write port and one registered read port.
module bias_regfile
    import bias_pkg::*;
#(
    parameter int unsigned OC = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [OUT_C_W-1:0] waddr,
    input  logic [BIAS_W-1:0]  wdata,
    input  logic               re,
    input  logic [OUT_C_W-1:0] raddr,
    output logic [BIAS_W-1:0]  rdata
);

    localparam int unsigned DEPTH = OC + 1;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BIAS_W-1:0] mem [DEPTH];
    logic              wr_in_range;
    logic              rd_in_range;

    assign wr_in_range = (32'(waddr) <= OC);
    assign rd_in_range = (32'(raddr) <= OC);

    // Contents are deliberately not reset; validity is tracked by the loader.
    always_ff @(posedge clk) begin
        if (we && wr_in_range) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rd_in_range ? mem[raddr[AW-1:0]] : '0;
        end
    end

endmodule

// File: rtl/bias_stream_loader.sv
// Loads signed bias bytes from a valid/ready stream into the per-layer bias store.
// Define BIAS_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module bias_stream_loader
    import bias_pkg::*;
#(
    parameter int unsigned OC = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    bias_stream_loader_if.slave s,
    output logic                loaded,
    output logic                err,
    input  logic                c_load,
    input  logic [OUT_C_W-1:0]  out_c,
    output logic [BIAS_W-1:0]   bias
);

    localparam logic [OUT_C_W-1:0] LAST = OUT_C_W'(OC);

    state_t             state_q;
    logic [OUT_C_W-1:0] addr_q;
    logic               loaded_q;
    logic               gate_q;
    logic               accept;
    logic               we;
    logic [BIAS_W-1:0]  rdata;
`ifdef BIAS_CHECKSUM_EN
    logic [BIAS_W-1:0]  sum_q;
    logic               err_q;
`endif

`ifdef BIAS_CHECKSUM_EN
    assign s.ready = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign err     = err_q;
`else
    assign s.ready = (state_q == S_LOAD);
    assign err     = 1'b0;
`endif

    // start wins over a coincident transfer; that byte is dropped.
    assign accept = s.valid && s.ready && !start;
    assign we     = accept && (state_q == S_LOAD);
    assign loaded = loaded_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            loaded_q <= 1'b0;
`ifdef BIAS_CHECKSUM_EN
            sum_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else if (start) begin
            state_q  <= S_LOAD;
            addr_q   <= '0;
            loaded_q <= 1'b0;
`ifdef BIAS_CHECKSUM_EN
            sum_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else if (accept) begin
            case (state_q)
                S_LOAD: begin
                    addr_q <= addr_q + 1'b1;
`ifdef BIAS_CHECKSUM_EN
                    sum_q  <= csum_add(sum_q, s.data);
                    if (addr_q == LAST) begin
                        state_q <= S_CHECK;
                    end
`else
                    if (addr_q == LAST) begin
                        state_q  <= S_DONE;
                        loaded_q <= 1'b1;
                    end
`endif
                end
`ifdef BIAS_CHECKSUM_EN
                S_CHECK: begin
                    if (s.data == sum_q) begin
                        state_q  <= S_DONE;
                        loaded_q <= 1'b1;
                    end else begin
                        state_q <= S_ERROR;
                        err_q   <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Validity of the read is captured alongside the data so bias holds when c_load is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gate_q <= 1'b0;
        end else if (c_load) begin
            gate_q <= loaded_q;
        end
    end

    assign bias = gate_q ? rdata : '0;

    bias_regfile #(
        .OC (OC)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (addr_q),
        .wdata (s.data),
        .re    (c_load),
        .raddr (out_c),
        .rdata (rdata)
    );

endmodule

// File: doc/bias_stream_loader.md
Name: bias_stream_loader

Overview:
- Write-side counterpart to the convolution bias read port: accepts signed 8-bit bias bytes over a valid/ready stream, e.g. from the UART RX byte stream.
- Writes bytes sequentially into an internal bias store of OC+1 entries.
- Serves the conv layer's existing read interface (c_load/out_c -> bias).
- Allows bias reload at run time without re-synthesising ROM images; one instance per conv layer.

Parameters:
- OC, 7, out_channels - 1; store depth is OC+1 (7 for conv1, 15 for conv2; max 15).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins (or restarts) a load sequence
- s_valid  in  1  input byte valid
- s_data  in  8  signed bias byte (two's complement)
- s_ready  out  1  loader accepts byte this cycle
- loaded  out  1  store holds a complete, accepted bias set
- err  out  1  checksum failure (BIAS_CHECKSUM_EN only; else constant 0)
- c_load  in  1  read strobe from conv controller
- out_c  in  4  channel index to read
- bias  out  8  signed bias for out_c, registered

Behaviour:
- Reset (rst low, async): state IDLE, write address 0, s_ready 0, loaded 0, err 0, bias 0. Store contents are not reset.
- States: IDLE, LOAD, CHECK (checksum build only), DONE, ERROR.
- IDLE/DONE/ERROR + start -> LOAD next cycle.
  - On that edge: address cleared to 0, loaded cleared to 0, err cleared to 0, checksum accumulator cleared to 0.
- LOAD:
  - s_ready = 1 combinationally while in LOAD; 0 in all other states.
  - Transfer occurs when s_valid && s_ready; store[addr] <= s_data; addr increments.
  - s_valid low stalls with no effect; there is no timeout.
  - Transfer with addr == OC -> DONE (plain build) or CHECK (checksum build).
  - DONE sets loaded = 1.
  - start during LOAD: restart, address back to 0, partial data discarded. start has priority over a simultaneous transfer, and that byte is not written.
- DONE: loaded = 1 and held until start or reset. Further s_valid is ignored because s_ready = 0.
- Read port (independent of load FSM):
  - c_load high -> bias <= store[out_c] on the next rising edge, only if loaded == 1 and out_c <= OC. Otherwise bias <= 0.
  - c_load low -> bias holds its value.
  - Latency 1 cycle, one read per cycle.
- Simultaneous final write and c_load: loaded is still 0 in that cycle, so bias <= 0. The read returns new data from the following cycle.
- Arithmetic: bias bytes are stored and returned verbatim, with no sign extension in this block.
- Reset mid-load: all state returns to reset values; stored bytes are undefined for use because loaded = 0.

Optional Feature:
- Macro BIAS_CHECKSUM_EN.
- Defined:
  - Accumulator = 8-bit sum, mod 256, of all accepted data bytes.
  - After the last data byte the FSM enters CHECK, with s_ready = 1.
  - The next transfer is the checksum byte. Equal to accumulator -> DONE, loaded = 1. Mismatch -> ERROR, err = 1, loaded = 0.
  - ERROR holds until start or reset.
  - start in CHECK restarts as in LOAD.
- Undefined: no CHECK or ERROR state, err tied to 0, and the stream is exactly OC+1 bytes.

Decomposition:
- Package bias_pkg:
  - BIAS_W = 8, OUT_C_W = 4.
  - State encoding constants S_IDLE, S_LOAD, S_CHECK, S_DONE, S_ERROR (3-bit).
- Sub-module bias_regfile:
  - Register array, one write port, one registered read port.
  - Parameter OC; ports clk, rst, we, waddr, wdata, re, raddr, rdata.
- bias_stream_loader holds the FSM, counter, checksum and read gating.

Test Plan:
- Reset, then c_load=1, out_c=3 -> bias stays 0, loaded 0, s_ready 0.
- start, stream 8'h01..8'h08 with s_valid always high (OC=7) -> s_ready high for 8 cycles, then loaded=1. c_load out_c=0..7 returns 1..8, each one cycle after the strobe. out_c=9 -> 0.
- Same stream with s_valid toggling every other cycle, plus start asserted after 3 bytes, then a full stream 8'hF0..8'hF7 -> the restart byte is not written, and final reads return 0xF0..0xF7 (signed -16..-9).
- OC=15: 16 bytes loaded -> loaded=1 after the 16th transfer. A 17th s_valid is not accepted (s_ready=0).
- BIAS_CHECKSUM_EN:
  - Bytes 8'h01..8'h08 then 8'h24 -> loaded=1, err=0.
  - Repeat with checksum 8'h25 -> err=1, loaded=0, reads return 0.
  - start then clears err.
- Assert rst low mid-LOAD (after 4 bytes) -> outputs return to 0 asynchronously. After release, the FSM is in IDLE and needs start.
